// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter (and the receiver):
//   - tx_state_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - PAR_EVEN / PAR_ODD : parity-type selector values
//   - IDLE_BIT / START_BIT / STOP_BIT : serial line levels
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_parity_calc.sv
// -----------------------------------------------------------------------------
// uart_tx_parity_calc
// Combinational parity generator shared by the UART transmitter and the
// receiver's parity checker.
// Ports:
//   data     in  DATA_WIDTH  payload bits
//   par_typ  in  1           PAR_EVEN (0) or PAR_ODD (1)
//   par      out 1           parity bit to place on the line
// -----------------------------------------------------------------------------
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);

  // Even parity is the XOR of the payload; odd parity is its inverse.
  always_comb begin
    par = 1'b0;
    if (par_typ == PAR_ODD) begin
      par = ~(^data);
    end else begin
      par = ^data;
    end
  end

endmodule : uart_tx_parity_calc

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter running on the divided TX clock: one line bit per clock.
// Frame = start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Ports:
//   i_tx_clk      in  1           TX clock, rising edge
//   i_rst         in  1           synchronous active-high reset
//   i_p_data      in  DATA_WIDTH  payload, captured only on acceptance
//   i_data_valid  in  1           send request, honoured only in IDLE
//   i_par_en      in  1           1 = append parity bit
//   i_par_typ     in  1           0 = even, 1 = odd parity
//   o_tx_out      out 1           serial line (flop output, idles high)
//   o_busy        out 1           high from start bit through stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_tx_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [DATA_WIDTH-1:0] frame_data;
  logic                  frame_par_en;
  logic                  frame_par_typ;
  logic                  frame_par_bit;
  logic                  tx_out;
  logic                  busy;

  assign cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Parity is derived from the frame registers, so mid-frame input changes
  // cannot disturb the bit on the line.
  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (frame_data),
    .par_typ (frame_par_typ),
    .par     (frame_par_bit)
  );

  // Frame FSM. The line value for the *next* state is registered on the same
  // edge as the state change, so o_tx_out always comes straight from a flop.
  always_ff @(posedge i_tx_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      frame_data    <= '0;
      frame_par_en  <= 1'b0;
      frame_par_typ <= 1'b0;
      tx_out        <= IDLE_BIT;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_data_valid) begin
            frame_data    <= i_p_data;
            frame_par_en  <= i_par_en;
            frame_par_typ <= i_par_typ;
            state         <= START;
            tx_out        <= START_BIT;
            busy          <= 1'b1;
          end else begin
            tx_out <= IDLE_BIT;
            busy   <= 1'b0;
          end
        end

        START: begin
          state  <= DATA;
          cnt    <= '0;
          tx_out <= frame_data[0];
          busy   <= 1'b1;
        end

        DATA: begin
          busy <= 1'b1;
          if (cnt == LAST_BIT) begin
            if (frame_par_en) begin
              state  <= PARITY;
              tx_out <= frame_par_bit;
            end else begin
              state  <= STOP;
              tx_out <= STOP_BIT;
            end
          end else begin
            cnt    <= cnt_next;
            tx_out <= frame_data[cnt_next];
          end
        end

        PARITY: begin
          state  <= STOP;
          tx_out <= STOP_BIT;
          busy   <= 1'b1;
        end

        STOP: begin
          // Leaving STOP always passes through IDLE, giving the mandatory
          // idle cycle between frames.
          state  <= IDLE;
          tx_out <= IDLE_BIT;
          busy   <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_out <= IDLE_BIT;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_out = tx_out;
  assign o_busy   = busy;

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .i_tx_clk     (clk),
    .i_rst        (rst),
    .i_p_data     (p_data),
    .i_data_valid (data_valid),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .o_tx_out     (tx_out),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record the line while busy, starting at the current (start-bit) sample.
  // Stops at the first idle sample or after 15 cycles.
  task automatic capture(output logic [15:0] bits, output int nbusy);
    int n;
    bits = '0;
    n = 0;
    while (busy === 1'b1 && n < 15) begin
      bits[n] = tx_out;
      n++;
      tick();
    end
    nbusy = n;
  endtask

  // Drive one request pulse; returns sampled just after the accepting edge.
  task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
    tick(); tick();
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_cycle_%0d: tx=%b busy=%b, required tx=1 busy=0", i, tx_out, busy);
      end
    end
  endtask

  task automatic test_no_parity();
    logic [15:0] bits;
    int nb;
    accept(8'hA5, 1'b0, 1'b0);
    capture(bits, nb);
    total++;
    if (bits[9:0] !== 10'b11_0100_1010) begin
      bad++;
      $display("FAIL a5_frame: line=%b, required %b", bits[9:0], 10'b11_0100_1010);
    end
    total++;
    if (nb !== 10) begin
      bad++;
      $display("FAIL a5_busy_len: busy cycles=%0d, required 10", nb);
    end
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL a5_after: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
    end
  endtask

  task automatic test_parity();
    logic [15:0] bits;
    int nb;
    // 0x07 has three ones: even parity bit 1.
    accept(8'h07, 1'b1, 1'b0);
    capture(bits, nb);
    total++;
    if (bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin
      bad++;
      $display("FAIL even_frame: line=%b, required %b", bits[10:0], {1'b1, 1'b1, 8'h07, 1'b0});
    end
    total++;
    if (nb !== 11) begin
      bad++;
      $display("FAIL even_busy_len: busy cycles=%0d, required 11", nb);
    end
    tick();
    // Odd parity bit 0; config flipped mid-frame must not matter.
    accept(8'h07, 1'b1, 1'b1);
    par_typ = 1'b0; par_en = 1'b0; p_data = 8'hFF;
    capture(bits, nb);
    total++;
    if (bits[10:0] !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
      bad++;
      $display("FAIL odd_frame: line=%b, required %b", bits[10:0], {1'b1, 1'b0, 8'h07, 1'b0});
    end
    total++;
    if (nb !== 11) begin
      bad++;
      $display("FAIL odd_busy_len: busy cycles=%0d, required 11", nb);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    int nb;
    p_data = 8'h81; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    tick();
    p_data = 8'h3C;  // valid stays high
    capture(bits, nb);
    total++;
    if (bits[9:0] !== {1'b1, 8'h81, 1'b0} || nb !== 10) begin
      bad++;
      $display("FAIL b2b_first: line=%b len=%0d, required %b len=10", bits[9:0], nb, {1'b1, 8'h81, 1'b0});
    end
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
    end
    tick();
    data_valid = 1'b0;
    total++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart: tx=%b busy=%b, required tx=0 busy=1", tx_out, busy);
    end
    capture(bits, nb);
    total++;
    if (bits[9:0] !== {1'b1, 8'h3C, 1'b0} || nb !== 10) begin
      bad++;
      $display("FAIL b2b_second: line=%b len=%0d, required %b len=10", bits[9:0], nb, {1'b1, 8'h3C, 1'b0});
    end
    tick();
  endtask

  task automatic test_midframe_reset();
    logic [15:0] bits;
    int nb;
    accept(8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();  // now showing data bit 4
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL bit4_before_reset: tx=%b busy=%b, required tx=1 busy=1", tx_out, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_midframe: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
    end
    tick();
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_stays_idle: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
    end
    accept(8'hFF, 1'b0, 1'b0);
    capture(bits, nb);
    total++;
    if (bits[9:0] !== {1'b1, 8'hFF, 1'b0} || nb !== 10) begin
      bad++;
      $display("FAIL ff_after_reset: line=%b len=%0d, required %b len=10", bits[9:0], nb, {1'b1, 8'hFF, 1'b0});
    end
    tick();
  endtask

  task automatic test_ignore_valid();
    logic [15:0] bits;
    int n;
    accept(8'h55, 1'b0, 1'b0);
    bits = '0;
    n = 0;
    while (busy === 1'b1 && n < 15) begin
      bits[n] = tx_out;
      // Pulse during START (n=0), DATA (n=4) and STOP (n=9) with other data.
      data_valid = (n == 0 || n == 4 || n == 9);
      p_data = 8'hC3; par_en = 1'b1;
      n++;
      tick();
    end
    data_valid = 1'b0;
    total++;
    if (bits[9:0] !== {1'b1, 8'h55, 1'b0} || n !== 10) begin
      bad++;
      $display("FAIL ignore_frame: line=%b len=%0d, required %b len=10", bits[9:0], n, {1'b1, 8'h55, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL ignore_no_extra_%0d: tx=%b busy=%b, required tx=1 busy=0", i, tx_out, busy);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_midframe_reset();
    test_ignore_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx_frame
